// File: rtl/cause_collector.sv
// cause_collector: builds ca[22:0] (reset cause, internal exceptions, 16 synchronised ext irqs) for interrupt_controller.
// Latency: internal causes 1 clk, ext_irq SYNC_STAGES clks after the sampling edge; ca is driven only from flops.
// No backpressure: causes stay pending until reset or jisr/il clears them. CAUSE_OVERRUN_CNT_EN adds ovr_cnt.
module cause_collector #(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [15:0] EXT_EDGE_MASK = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        ill,
  input  logic        mal,
  input  logic        pff,
  input  logic        pfls,
  input  logic        trap,
  input  logic        ovf,
  input  logic [15:0] ext_irq,
  input  logic        jisr,
  input  logic [4:0]  il,
  output logic [22:0] ca
`ifdef CAUSE_OVERRUN_CNT_EN
  ,
  output logic [15:0] ovr_cnt
`endif
);

  logic        rst_cause_q;
  logic [5:0]  int_cause_q;
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] sync_s;
  logic [15:0] sync_p_q;
  logic [15:0] edge_det;
  logic [15:0] ext_clr;
  logic [15:0] pend_q;
  logic [15:0] pend_d;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_s & ~sync_p_q & EXT_EDGE_MASK;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      ext_clr[k] = jisr && (il == 5'(k + 7));
    end
  end

  // Edge lines: a new edge beats a same-cycle clear. Level lines just follow the synchroniser.
  assign pend_d = (EXT_EDGE_MASK & (edge_det | (pend_q & ~ext_clr)))
                | (~EXT_EDGE_MASK & sync_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_p_q <= '0;
      pend_q   <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_p_q <= sync_s;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cause_q <= 1'b1;
    end else if (jisr && il == 5'd0) begin
      rst_cause_q <= 1'b0;
    end
  end

  // A taken interrupt aborts the current instruction, so its sampled causes are discarded.
  always_ff @(posedge clk) begin
    if (reset || jisr) begin
      int_cause_q <= '0;
    end else if (instr_valid) begin
      int_cause_q <= {ovf, trap, pfls, pff, mal, ill};
    end
  end

  assign ca = {pend_q, int_cause_q, rst_cause_q};

`ifdef CAUSE_OVERRUN_CNT_EN
  logic ovr_hit;

  assign ovr_hit = |(edge_det & pend_q & ~ext_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt <= '0;
    end else if (ovr_hit && ovr_cnt != 16'hFFFF) begin
      ovr_cnt <= ovr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cause_collector.sv
// Scoreboard bench for cause_collector: expected ca values are queued against a target edge when stimulus is driven.
module tb_cause_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, ill, mal, pff, pfls, trap, ovf;
  logic [15:0] ext_irq;
  logic        jisr;
  logic [4:0]  il;
  logic [22:0] ca;
`ifdef CAUSE_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  typedef struct {
    int          cyc;
    logic [22:0] mask;
    logic [22:0] val;
    string       tag;
  } sb_t;

  sb_t sb[$];

  cause_collector #(
    .SYNC_STAGES  (2),
    .EXT_EDGE_MASK(16'hFFFE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .ill        (ill),
    .mal        (mal),
    .pff        (pff),
    .pfls       (pfls),
    .trap       (trap),
    .ovf        (ovf),
    .ext_irq    (ext_irq),
    .jisr       (jisr),
    .il         (il),
    .ca         (ca)
`ifdef CAUSE_OVERRUN_CNT_EN
    ,
    .ovr_cnt    (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, cyc_n);
    end
  endtask

  // Queue an expectation for the ca value seen just after edge (cyc_n + dly).
  function automatic void exp_at(input int dly, input logic [22:0] mask, input logic [22:0] val,
                                 input string tag);
    sb_t e;
    int  i;
    e.cyc  = cyc_n + dly;
    e.mask = mask;
    e.val  = val;
    e.tag  = tag;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endfunction

  always begin
    sb_t e;
    @(posedge clk);
    cyc_n++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      e = sb.pop_front();
      chk(e.tag, 32'(ca & e.mask), 32'(e.val & e.mask));
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  localparam logic [22:0] ALL = 23'h7FFFFF;

  initial begin
    reset = 1'b1; instr_valid = 0; ill = 0; mal = 0; pff = 0; pfls = 0; trap = 0; ovf = 0;
    ext_irq = '0; jisr = 0; il = '0;

    // Reset held for three edges.
    exp_at(1, ALL, 23'h000001, "rst_e1");
    nxt(); exp_at(1, ALL, 23'h000001, "rst_e2");
    nxt(); exp_at(1, ALL, 23'h000001, "rst_e3");
    nxt(); reset = 1'b0;
    exp_at(1, ALL, 23'h000001, "rst_hold1");
    exp_at(3, ALL, 23'h000001, "rst_hold3");
    nxt(); nxt(); nxt();
    jisr = 1; il = 5'd0; exp_at(1, ALL, 23'h000000, "rst_clr");
    nxt(); jisr = 0;

    // Internal causes: load, hold while stalled, jisr priority, reload.
    instr_valid = 1; ovf = 1; mal = 1; exp_at(1, ALL, 23'h000044, "int_load");
    nxt(); instr_valid = 0; ovf = 0; mal = 0; ill = 1; trap = 1;
    exp_at(1, ALL, 23'h000044, "int_hold");
    nxt(); instr_valid = 1; jisr = 1; il = 5'd5; exp_at(1, ALL, 23'h000000, "int_jisr_abort");
    nxt(); jisr = 0; exp_at(1, ALL, 23'h000022, "int_reload");
    nxt(); instr_valid = 0; jisr = 1; il = 5'd0; exp_at(1, ALL, 23'h000000, "int_clr");
    nxt(); jisr = 0; ill = 0; trap = 0;

    // Edge line 3: one-cycle pulse, two-edge latency, sticky, wrong-index clear ignored.
    ext_irq[3] = 1'b1;
    exp_at(2, ALL, 23'h000000, "edge_not_yet");
    exp_at(3, ALL, 23'h000400, "edge_arrive");
    nxt(); ext_irq[3] = 1'b0;
    nxt();
    for (int i = 0; i < 10; i++) begin
      nxt(); exp_at(1, ALL, 23'h000400, "edge_sticky");
    end
    jisr = 1; il = 5'd11; exp_at(1, ALL, 23'h000400, "edge_il11_keep");
    nxt(); il = 5'd10; exp_at(1, ALL, 23'h000000, "edge_il10_clr");
    nxt(); jisr = 0;

    // Set-wins: second edge reaches the detector on the same edge as the clear.
    ext_irq[3] = 1'b1; exp_at(3, ALL, 23'h000400, "sw_first");
    nxt(); ext_irq[3] = 1'b0;
    nxt();
    nxt(); ext_irq[3] = 1'b1;
    nxt(); ext_irq[3] = 1'b0;
    nxt(); jisr = 1; il = 5'd10;
    exp_at(1, ALL, 23'h000400, "sw_set_wins");
    exp_at(2, ALL, 23'h000400, "sw_after");
    nxt(); jisr = 0;
    nxt(); jisr = 1; il = 5'd10; exp_at(1, ALL, 23'h000000, "sw_clr");
    nxt(); jisr = 0;

    // Level line 0: follows the line, immune to jisr.
    ext_irq[0] = 1'b1;
    exp_at(2, ALL, 23'h000000, "lvl_not_yet");
    exp_at(3, ALL, 23'h000080, "lvl_arrive");
    nxt(); nxt(); nxt();
    jisr = 1; il = 5'd7; exp_at(1, ALL, 23'h000080, "lvl_jisr_keep");
    nxt(); jisr = 0;
    nxt(); ext_irq[0] = 1'b0;
    exp_at(2, ALL, 23'h000080, "lvl_drop_wait");
    exp_at(3, ALL, 23'h000000, "lvl_drop");
    nxt(); nxt(); nxt();

    // Mid-operation reset drops internal state and an edge in flight.
    instr_valid = 1; pff = 1; ext_irq[3] = 1'b1; exp_at(1, ALL, 23'h000008, "mr_pre");
    nxt(); instr_valid = 0; pff = 0; ext_irq[3] = 1'b0; reset = 1'b1;
    exp_at(1, ALL, 23'h000001, "mr_reset");
    nxt(); reset = 1'b0;
    exp_at(1, ALL, 23'h000001, "mr_drop1");
    exp_at(2, ALL, 23'h000001, "mr_drop2");
    exp_at(3, ALL, 23'h000001, "mr_drop3");
    nxt(); nxt(); nxt();

`ifdef CAUSE_OVERRUN_CNT_EN
    chk("ovr_zero", 32'(ovr_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ext_irq[5] = 1'b1; nxt();
      ext_irq[5] = 1'b0; nxt();
    end
    nxt(); nxt(); nxt();
    chk("ovr_three_edges", 32'(ovr_cnt), 32'd2);
    exp_at(0, 23'h001000, 23'h001000, "ovr_pending");
    nxt();
`endif

    nxt(); nxt(); nxt();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
